multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
FSM-based control unit for the multi-cycle RV32I core. It is the successor to the single-cycle combinational decoder. It sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and waits on a variable-latency memory handshake. It adds a bus timeout and an illegal-instruction trap that halts the core. It sits between the instruction register, datapath muxes, ALU, register file and the unified memory port.

Parameters:
MEM_TIMEOUT, 15, consecutive not-ready cycles tolerated on mem_req before the timeout trap; legal range 1..255.
TIMEOUT_EN, 1, 0 disables the timeout counter entirely.
ALU_CTRL_W, 5, width of ALU_control; must be at least 5.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
instruction  in  32  IR output; valid and stable from DECODE until the instruction retires
zero  in  1  ALU condition flag; 1 means the branch condition holds
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request; address comes from PC (fetch) or ALU (data)
mem_addr_src  out  1  0 = PC, 1 = ALU result
memory_write  out  1  store strobe; qualifies mem_req
memory_mode  out  4  0 BYTE, 1 HALF, 2 WORD, 3 UBYTE, 4 UHALF
ir_write  out  1  load IR with memory read data
pc_write  out  1  update PC this cycle
PC_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL)
ALU_src  out  1  0 = rs2, 1 = immediate
imm_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J
ALU_control  out  ALU_CTRL_W  ADD1 SUB2 XOR3 OR4 AND5 SLL6 SRL7 SRA8 SLT9 SLTU10 BEQ11 BNE12 BLT13 BGE14 BLTU15 BGEU16 JAL17 LUI18; 0 default
reg_write  out  1  register-file write enable
reg_write_mode  out  2  0 ALU, 1 memory, 2 PC+4, 3 immediate
state  out  3  FETCH0 DECODE1 EXECUTE2 MEM3 WRITEBACK4 TRAP5
illegal  out  1  sticky; set on an unsupported opcode or funct
timeout  out  1  sticky; set on memory timeout

Behaviour:
- Reset (async):
  - State goes to FETCH; the timeout counter and both sticky flags clear.
  - All strobes (mem_req, memory_write, ir_write, pc_write, reg_write) are 0; every other output is 0.
  - The first mem_req is asserted in the first cycle after reset deasserts.
- FETCH:
  - mem_req=1, mem_addr_src=0, memory_mode=WORD.
  - On mem_ready: ir_write=1 in that same cycle (Mealy), then go to DECODE.
  - Otherwise hold.
- DECODE:
  - Check opcode and funct. Supported opcodes: R, I, load, store, branch, JAL, LUI. Everything else, including AUIPC, JALR and SYSTEM, is illegal.
  - R-type SUB and SRA use funct7=0100000. SRAI uses imm[11:5]=0100000. Any other funct7 is illegal. Load funct3 3, 6 and 7, store funct3 above 2, and branch funct3 2/3 are illegal.
  - Illegal: set illegal=1 and go to TRAP. Legal: go to EXECUTE.
- EXECUTE (ALU_control, ALU_src and imm_src valid this cycle):
  - R, I, LUI: go to WRITEBACK.
  - Load, store: go to MEM.
  - Branch: pc_write=1, PC_src=zero?1:0, then go to FETCH.
  - JAL: reg_write=1, reg_write_mode=2, pc_write=1, PC_src=1, then go to FETCH.
- MEM:
  - mem_req=1, mem_addr_src=1, memory_mode decoded from funct3, memory_write=1 for stores.
  - Store on mem_ready: pc_write=1, PC_src=0, go to FETCH.
  - Load on mem_ready: go to WRITEBACK.
- WRITEBACK:
  - reg_write=1, with reg_write_mode 0 (R/I), 1 (load) or 3 (LUI).
  - pc_write=1, PC_src=0, then go to FETCH.
- Latencies with zero-wait memory:
  - R, I, LUI, store: 4 cycles.
  - Load: 5 cycles.
  - Branch, JAL: 3 cycles.
  - Each not-ready cycle adds 1.
- Timeout (TIMEOUT_EN=1):
  - The counter increments each cycle mem_req=1 and mem_ready=0. It clears on mem_ready and on any state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, set timeout=1 and go to TRAP.
  - If mem_ready arrives on the same cycle as the limit, the handshake wins.
- TRAP:
  - All strobes are 0; stay in TRAP until reset. illegal and timeout stay readable.
- Strobe rules:
  - pc_write and reg_write never assert outside the cases listed above.
  - memory_write=1 only when mem_req=1.
  - zero is ignored outside EXECUTE of a branch.

Test Plan:
- Reset mid-MEM on a store, then release: memory_write drops immediately; state=0; the next mem_req has mem_addr_src=0.
- R-type SUB (funct7 0100000, funct3 0) with mem_ready tied 1: states 0,1,2,4,0; ALU_control=2 in EXECUTE; reg_write=1 only in cycle 4; total 4 cycles.
- LH (funct3 1) with mem_ready delayed 3 cycles in MEM: memory_mode=1, reg_write_mode=1; 8 cycles total; no timeout.
- BNE with zero=1, then BNE with zero=0: PC_src=1 and PC_src=0 respectively, pc_write=1 in EXECUTE both times; 3 cycles each.
- Opcode 0010111 (AUIPC): illegal=1, state=5 after DECODE; no further mem_req until reset.
- MEM_TIMEOUT=4 and mem_ready held 0 in FETCH: timeout=1 on the 5th request cycle, state=5. Repeat with mem_ready on the 4th stall cycle: no trap.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Unified memory port between the multi-cycle control unit and memory.
// Control drives request/address-select/write/mode, memory answers with mem_ready.
interface multicycle_control_unit_if;
  logic       mem_req;
  logic       mem_addr_src;
  logic       memory_write;
  logic [3:0] memory_mode;
  logic       mem_ready;

  modport master (output mem_req, mem_addr_src, memory_write, memory_mode, input mem_ready);
  modport slave  (input mem_req, mem_addr_src, memory_write, memory_mode, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// FSM control unit for the multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// sequencing, variable-latency memory handshake, bus timeout and illegal-instruction trap.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit TIMEOUT_EN  = 1'b1,
  parameter int ALU_CTRL_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instruction,
  input  logic                      zero,
  multicycle_control_unit_if.master bus,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic [1:0]                PC_src,
  output logic                      ALU_src,
  output logic [2:0]                imm_src,
  output logic [ALU_CTRL_W-1:0]     ALU_control,
  output logic                      reg_write,
  output logic [1:0]                reg_write_mode,
  output logic [2:0]                state,
  output logic                      illegal,
  output logic                      timeout
);
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXECUTE = 3'd2,
    ST_MEM = 3'd3, ST_WRITEBACK = 3'd4, ST_TRAP = 3'd5
  } state_t;

  typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI} cls_t;

  typedef struct packed {
    cls_t                  cls;
    logic [ALU_CTRL_W-1:0] alu;
    logic                  alu_src;
    logic [2:0]            imm;
    logic [3:0]            mode;
    logic                  bad;
  } dec_t;

  state_t     st;
  dec_t       dec, dq;
  logic [7:0] tmo_cnt;
  logic       stall, tmo_hit;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  logic unused_instr;
  assign unused_instr = ^{instruction[24:15], instruction[11:7]};

  function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [4:0] c;
    case (f3)
      3'd0:    c = alt ? 5'd2 : 5'd1;
      3'd1:    c = 5'd6;
      3'd2:    c = 5'd9;
      3'd3:    c = 5'd10;
      3'd4:    c = 5'd3;
      3'd5:    c = alt ? 5'd8 : 5'd7;
      3'd6:    c = 5'd4;
      default: c = 5'd5;
    endcase
    return ALU_CTRL_W'(c);
  endfunction

  always_comb begin
    dec = '0;
    case (opcode)
      7'b0110011: begin
        dec.cls = C_R;
        if (funct7 == 7'b0000000) dec.alu = alu_op(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
          dec.alu = alu_op(funct3, 1'b1);
        else dec.bad = 1'b1;
      end
      7'b0010011: begin
        dec.cls     = C_I;
        dec.alu_src = 1'b1;
        // only the shift-immediates constrain imm[11:5]
        if (funct3 == 3'd1 && funct7 != 7'b0000000) dec.bad = 1'b1;
        if (funct3 == 3'd5 && funct7 != 7'b0000000 && funct7 != 7'b0100000) dec.bad = 1'b1;
        dec.alu = alu_op(funct3, funct3 == 3'd5 && funct7 == 7'b0100000);
      end
      7'b0000011: begin
        dec.cls     = C_LOAD;
        dec.alu     = ALU_CTRL_W'(5'd1);
        dec.alu_src = 1'b1;
        case (funct3)
          3'd0, 3'd1, 3'd2: dec.mode = {1'b0, funct3};
          3'd4:             dec.mode = 4'd3;
          3'd5:             dec.mode = 4'd4;
          default:          dec.bad  = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.cls     = C_STORE;
        dec.alu     = ALU_CTRL_W'(5'd1);
        dec.alu_src = 1'b1;
        dec.imm     = 3'd1;
        dec.mode    = {1'b0, funct3};
        if (funct3 > 3'd2) dec.bad = 1'b1;
      end
      7'b1100011: begin
        dec.cls = C_BRANCH;
        dec.imm = 3'd2;
        case (funct3)
          3'd0:    dec.alu = ALU_CTRL_W'(5'd11);
          3'd1:    dec.alu = ALU_CTRL_W'(5'd12);
          3'd4:    dec.alu = ALU_CTRL_W'(5'd13);
          3'd5:    dec.alu = ALU_CTRL_W'(5'd14);
          3'd6:    dec.alu = ALU_CTRL_W'(5'd15);
          3'd7:    dec.alu = ALU_CTRL_W'(5'd16);
          default: dec.bad = 1'b1;
        endcase
      end
      7'b1101111: begin
        dec.cls     = C_JAL;
        dec.alu     = ALU_CTRL_W'(5'd17);
        dec.alu_src = 1'b1;
        dec.imm     = 3'd4;
      end
      7'b0110111: begin
        dec.cls     = C_LUI;
        dec.alu     = ALU_CTRL_W'(5'd18);
        dec.alu_src = 1'b1;
        dec.imm     = 3'd3;
      end
      default: dec.bad = 1'b1;
    endcase
  end

  // a handshake landing on the limit cycle wins over the timeout
  assign stall   = TIMEOUT_EN && bus.mem_req && !bus.mem_ready;
  assign tmo_hit = stall && (tmo_cnt == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= ST_FETCH;
      tmo_cnt <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      dq      <= '0;
    end else begin
      tmo_cnt <= (stall && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;
      if (tmo_hit) begin
        st      <= ST_TRAP;
        timeout <= 1'b1;
      end else begin
        case (st)
          ST_FETCH: if (bus.mem_ready) st <= ST_DECODE;
          ST_DECODE: begin
            dq <= dec;
            if (dec.bad) begin
              illegal <= 1'b1;
              st      <= ST_TRAP;
            end else st <= ST_EXECUTE;
          end
          ST_EXECUTE: begin
            case (dq.cls)
              C_LOAD, C_STORE: st <= ST_MEM;
              C_BRANCH, C_JAL: st <= ST_FETCH;
              default:         st <= ST_WRITEBACK;
            endcase
          end
          ST_MEM:       if (bus.mem_ready) st <= (dq.cls == C_STORE) ? ST_FETCH : ST_WRITEBACK;
          ST_WRITEBACK: st <= ST_FETCH;
          ST_TRAP:      st <= ST_TRAP;
          default:      st <= ST_FETCH;
        endcase
      end
    end
  end

  assign state = st;

  // outputs are gated by reset so every strobe is low while reset is held
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.memory_write = 1'b0;
    bus.memory_mode  = 4'd0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    PC_src           = 2'd0;
    ALU_src          = 1'b0;
    imm_src          = 3'd0;
    ALU_control      = '0;
    reg_write        = 1'b0;
    reg_write_mode   = 2'd0;
    if (!reset) begin
      if (st == ST_EXECUTE || st == ST_MEM || st == ST_WRITEBACK) begin
        ALU_control = dq.alu;
        ALU_src     = dq.alu_src;
        imm_src     = dq.imm;
      end
      case (st)
        ST_FETCH: begin
          bus.mem_req     = 1'b1;
          bus.memory_mode = 4'd2;
          ir_write        = bus.mem_ready;
        end
        ST_EXECUTE: begin
          if (dq.cls == C_BRANCH) begin
            pc_write = 1'b1;
            PC_src   = {1'b0, zero};
          end else if (dq.cls == C_JAL) begin
            pc_write       = 1'b1;
            PC_src         = 2'd1;
            reg_write      = 1'b1;
            reg_write_mode = 2'd2;
          end
        end
        ST_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_src = 1'b1;
          bus.memory_mode  = dq.mode;
          bus.memory_write = (dq.cls == C_STORE);
          pc_write         = (dq.cls == C_STORE) && bus.mem_ready;
        end
        ST_WRITEBACK: begin
          reg_write      = 1'b1;
          reg_write_mode = (dq.cls == C_LOAD) ? 2'd1 : (dq.cls == C_LUI) ? 2'd3 : 2'd0;
          pc_write       = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit (MEM_TIMEOUT=4).
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        ir_write, pc_write, ALU_src, reg_write, illegal, timeout;
  logic [1:0]  PC_src, reg_write_mode;
  logic [2:0]  imm_src, state;
  logic [4:0]  ALU_control;

  multicycle_control_unit_if mif();

  multicycle_control_unit #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b1), .ALU_CTRL_W(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .bus(mif),
    .ir_write(ir_write), .pc_write(pc_write), .PC_src(PC_src), .ALU_src(ALU_src),
    .imm_src(imm_src), .ALU_control(ALU_control), .reg_write(reg_write),
    .reg_write_mode(reg_write_mode), .state(state), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    int          cyc;
    logic [4:0]  alu;
    logic        src;
    logic [2:0]  imm;
    int          rw;
    logic [1:0]  rwm;
    logic [1:0]  pcsrc;
    logic        is_mem;
    logic [3:0]  mode;
    int          memw;
  } vec_t;

  vec_t tbl[$];

  int          g_cyc, g_rw, g_pcw, g_memw;
  logic [31:0] g_alu, g_src, g_imm, g_mode, g_rwm, g_pcsrc;

  // Runs one instruction from FETCH until it returns to FETCH or traps.
  task automatic run(input logic [31:0] ins, input logic z, input int fst, input int mst);
    int f = fst;
    int m = mst;
    instruction = ins;
    zero = z;
    g_cyc = 0; g_rw = 0; g_pcw = 0; g_memw = 0;
    g_alu = 0; g_src = 0; g_imm = 0; g_mode = 0; g_rwm = 0; g_pcsrc = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == 3'd0 && f > 0) begin mif.mem_ready = 1'b0; f--; end
      else if (state == 3'd3 && m > 0) begin mif.mem_ready = 1'b0; m--; end
      else mif.mem_ready = 1'b1;
      @(negedge clk);
      g_cyc++;
      if (state == 3'd2) begin g_alu = ALU_control; g_src = ALU_src; g_imm = imm_src; end
      if (state == 3'd3) begin
        g_mode = mif.memory_mode;
        if (mif.memory_write && mif.mem_req) g_memw++;
      end
      if (reg_write) begin g_rw++; g_rwm = reg_write_mode; end
      if (pc_write) begin g_pcw++; g_pcsrc = PC_src; end
      @(posedge clk); #1;
      if (state == 3'd0 || state == 3'd5) break;
    end
    mif.mem_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [31:0] bad_ins[8];
  int          strobes;

  initial begin
    tbl.push_back('{"add",  32'h003100B3, 1'b0, 4, 5'd1,  1'b0, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"sub",  32'h403100B3, 1'b0, 4, 5'd2,  1'b0, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"sra",  32'h403150B3, 1'b0, 4, 5'd8,  1'b0, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"sltu", 32'h003130B3, 1'b0, 4, 5'd10, 1'b0, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"addi", 32'h00510093, 1'b0, 4, 5'd1,  1'b1, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"srai", 32'h40315093, 1'b0, 4, 5'd8,  1'b1, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"andi", 32'h0FF17093, 1'b0, 4, 5'd5,  1'b1, 3'd0, 1, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"lw",   32'h00412083, 1'b0, 5, 5'd1,  1'b1, 3'd0, 1, 2'd1, 2'd0, 1'b1, 4'd2, 0});
    tbl.push_back('{"lbu",  32'h00414083, 1'b0, 5, 5'd1,  1'b1, 3'd0, 1, 2'd1, 2'd0, 1'b1, 4'd3, 0});
    tbl.push_back('{"lhu",  32'h00415083, 1'b0, 5, 5'd1,  1'b1, 3'd0, 1, 2'd1, 2'd0, 1'b1, 4'd4, 0});
    tbl.push_back('{"sw",   32'h00312423, 1'b0, 4, 5'd1,  1'b1, 3'd1, 0, 2'd0, 2'd0, 1'b1, 4'd2, 1});
    tbl.push_back('{"sb",   32'h00310423, 1'b0, 4, 5'd1,  1'b1, 3'd1, 0, 2'd0, 2'd0, 1'b1, 4'd0, 1});
    tbl.push_back('{"beq1", 32'h00310063, 1'b1, 3, 5'd11, 1'b0, 3'd2, 0, 2'd0, 2'd1, 1'b0, 4'd0, 0});
    tbl.push_back('{"bne1", 32'h00311063, 1'b1, 3, 5'd12, 1'b0, 3'd2, 0, 2'd0, 2'd1, 1'b0, 4'd0, 0});
    tbl.push_back('{"bne0", 32'h00311063, 1'b0, 3, 5'd12, 1'b0, 3'd2, 0, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"bgeu", 32'h00317063, 1'b0, 3, 5'd16, 1'b0, 3'd2, 0, 2'd0, 2'd0, 1'b0, 4'd0, 0});
    tbl.push_back('{"blt",  32'h00314063, 1'b1, 3, 5'd13, 1'b0, 3'd2, 0, 2'd0, 2'd1, 1'b0, 4'd0, 0});
    tbl.push_back('{"jal",  32'h000000EF, 1'b0, 3, 5'd17, 1'b1, 3'd4, 1, 2'd2, 2'd1, 1'b0, 4'd0, 0});
    tbl.push_back('{"lui",  32'h123450B7, 1'b0, 4, 5'd18, 1'b1, 3'd3, 1, 2'd3, 2'd0, 1'b0, 4'd0, 0});

    bad_ins = '{32'h00000097, 32'h023100B3, 32'h00013083, 32'h00313423,
                32'h00312063, 32'h40311093, 32'h00008067, 32'h00000073};

    // reset state
    reset = 1'b1; instruction = 32'h0; zero = 1'b0; mif.mem_ready = 1'b0;
    #12;
    check("rst_state", state, 0);
    check("rst_mem_req", mif.mem_req, 0);
    check("rst_mem_write", mif.memory_write, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_illegal", illegal, 0);
    check("rst_timeout", timeout, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_mem_req", mif.mem_req, 1);
    check("first_addr_src", mif.mem_addr_src, 0);
    check("first_mode", mif.memory_mode, 2);
    check("first_ir_write_stall", ir_write, 0);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      run(tbl[k].ins, tbl[k].z, 0, 0);
      check({tbl[k].name, "_cycles"}, g_cyc, tbl[k].cyc);
      check({tbl[k].name, "_alu"}, g_alu, tbl[k].alu);
      check({tbl[k].name, "_alu_src"}, g_src, tbl[k].src);
      check({tbl[k].name, "_imm_src"}, g_imm, tbl[k].imm);
      check({tbl[k].name, "_reg_writes"}, g_rw, tbl[k].rw);
      if (tbl[k].rw > 0) check({tbl[k].name, "_rw_mode"}, g_rwm, tbl[k].rwm);
      check({tbl[k].name, "_pc_writes"}, g_pcw, 1);
      check({tbl[k].name, "_pc_src"}, g_pcsrc, tbl[k].pcsrc);
      if (tbl[k].is_mem) begin
        check({tbl[k].name, "_mem_mode"}, g_mode, tbl[k].mode);
        check({tbl[k].name, "_mem_writes"}, g_memw, tbl[k].memw);
      end
      check({tbl[k].name, "_end_state"}, state, 0);
    end

    // LH with three not-ready cycles in MEM
    run(32'h00011083, 1'b0, 0, 3);
    check("lh_cycles", g_cyc, 8);
    check("lh_mode", g_mode, 1);
    check("lh_rw_mode", g_rwm, 1);
    check("lh_timeout", timeout, 0);
    check("lh_end_state", state, 0);

    // unsupported encodings trap and stay quiet until reset
    foreach (bad_ins[k]) begin
      run(bad_ins[k], 1'b0, 0, 0);
      check($sformatf("ill%0d_cycles", k), g_cyc, 2);
      check($sformatf("ill%0d_state", k), state, 5);
      check($sformatf("ill%0d_flag", k), illegal, 1);
      strobes = 0;
      repeat (3) begin
        @(negedge clk);
        if (mif.mem_req || pc_write || reg_write || ir_write) strobes++;
      end
      check($sformatf("ill%0d_quiet", k), strobes, 0);
      check($sformatf("ill%0d_still_trap", k), state, 5);
      reset = 1'b1; #2;
      check($sformatf("ill%0d_rst_clear", k), illegal, 0);
      @(posedge clk); #1; reset = 1'b0;
    end

    // timeout: four stalls tolerated, the fifth traps
    instruction = 32'h003100B3;
    pulse_reset();
    mif.mem_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("tmo_pre_state", state, 0);
    check("tmo_pre_flag", timeout, 0);
    @(posedge clk); #1;
    check("tmo_flag", timeout, 1);
    check("tmo_state", state, 5);
    @(negedge clk);
    check("tmo_no_req", mif.mem_req, 0);

    // handshake on the limit cycle wins
    pulse_reset();
    mif.mem_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("lim_ir_write", ir_write, 1);
    @(posedge clk); #1;
    check("lim_state", state, 1);
    check("lim_timeout", timeout, 0);

    // reset asserted mid-MEM of a store
    instruction = 32'h00312423;
    pulse_reset();
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (state == 3'd3) break;
    end
    check("st_reached_mem", state, 3);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check("st_mem_write", mif.memory_write, 1);
    #2 reset = 1'b1;
    #1;
    check("st_rst_mem_write", mif.memory_write, 0);
    check("st_rst_mem_req", mif.mem_req, 0);
    check("st_rst_state", state, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("st_next_req", mif.mem_req, 1);
    check("st_next_addr_src", mif.mem_addr_src, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
